// File: rtl/nn_zoom_in_if.sv
// ---------------------------------------------------------------------------
// nn_zoom_in_if
// Pixel stream bundle between the nearest-neighbour upscaler and whatever
// consumes its enlarged frame. A pixel moves on a rising clock edge where
// pix_valid and pix_ready are both high.
//
// Signals
//   pix_valid  master -> slave  pix_out and the frame flags are meaningful
//   pix_ready  slave  -> master consumer can take the current pixel
//   pix_out    master -> slave  pixel value, data_w bits
//   pix_sof    master -> slave  first pixel of the frame
//   pix_eol    master -> slave  last pixel of an output row
//   pix_eof    master -> slave  last pixel of the frame
//
// Modports
//   master  the upscaler side (drives data, samples ready)
//   slave   the consumer side (samples data, drives ready)
// ---------------------------------------------------------------------------
interface nn_zoom_in_if #(
  parameter int data_w = 8
);

  logic              pix_valid;
  logic              pix_ready;
  logic [data_w-1:0] pix_out;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;

  modport master (
    output pix_valid,
    output pix_out,
    output pix_sof,
    output pix_eol,
    output pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_out,
    input  pix_sof,
    input  pix_eol,
    input  pix_eof,
    output pix_ready
  );

endinterface

// File: rtl/nn_zoom_in.sv
// ---------------------------------------------------------------------------
// nn_zoom_in
// Nearest-neighbour upscaler. Holds one altura x largura source frame in a
// register buffer and, on start, streams the (altura*zoom_in) x
// (largura*zoom_in) enlarged frame in raster order. Every source pixel is
// repeated zoom_in times along a row and every source row is repeated
// zoom_in times down the frame.
//
// Parameters
//   largura  source width in pixels
//   altura   source height in pixels
//   zoom_in  integer replication factor, 1 or more
//   data_w   pixel width in bits
//
// Ports
//   clock    rising-edge clock for all state
//   reset    asynchronous, active-low reset (buffer contents are kept)
//   wr_en    source buffer write strobe, honoured only while idle
//   wr_addr  source index row*largura+col; indices past the frame are dropped
//   wr_data  source pixel value
//   start    launch one enlarged frame, sampled only while idle
//   busy     high from the accepted start until the last pixel is taken
//   done     one-cycle pulse following the edge that takes the last pixel
//   pix      pixel stream, master side (valid/ready, data, sof/eol/eof)
// ---------------------------------------------------------------------------
module nn_zoom_in #(
  parameter  int largura = 4,
  parameter  int altura  = 4,
  parameter  int zoom_in = 2,
  parameter  int data_w  = 8,
  localparam int AW      = (largura * altura > 1) ? $clog2(largura * altura) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [data_w-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  nn_zoom_in_if.master      pix
);

  localparam int N_SRC = largura * altura;
  localparam int CW_C  = (largura > 1) ? $clog2(largura) : 1;
  localparam int CW_R  = (altura  > 1) ? $clog2(altura)  : 1;
  localparam int CW_Z  = (zoom_in > 1) ? $clog2(zoom_in) : 1;

  localparam logic [CW_C-1:0] C_LAST = CW_C'(largura - 1);
  localparam logic [CW_R-1:0] R_LAST = CW_R'(altura - 1);
  localparam logic [CW_Z-1:0] Z_LAST = CW_Z'(zoom_in - 1);
  localparam logic [AW-1:0]   LARG_V = AW'(largura);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;

  logic [data_w-1:0] pix_buf [N_SRC];

  logic [CW_C-1:0]   src_col;
  logic [CW_Z-1:0]   rep_col;
  logic [CW_R-1:0]   src_row;
  logic [CW_Z-1:0]   rep_row;
  logic              more;

  logic              valid_reg;
  logic [data_w-1:0] out_reg;
  logic              sof_reg;
  logic              eol_reg;
  logic              eof_reg;

  logic [AW-1:0]     rd_addr;
  logic              col_last;
  logic              row_last;
  logic              at_first;
  logic              addr_ok;
  logic              advance;

  assign pix.pix_valid = valid_reg;
  assign pix.pix_out   = out_reg;
  assign pix.pix_sof   = sof_reg;
  assign pix.pix_eol   = eol_reg;
  assign pix.pix_eof   = eof_reg;

  // When the source frame fills the whole address space every wr_addr is
  // legal; otherwise indices at or beyond the frame size are discarded.
  generate
    if (N_SRC == (1 << AW)) begin : g_full_range
      assign addr_ok = 1'b1;
    end else begin : g_part_range
      assign addr_ok = (wr_addr < AW'(N_SRC));
    end
  endgenerate

  // Source index of the pixel the counters currently point at. The column
  // and row replication counters stand in for the divide by zoom_in, so only
  // a constant multiply by the row pitch remains.
  always_comb begin
    rd_addr  = AW'(src_row) * LARG_V + AW'(src_col);
    col_last = (rep_col == Z_LAST) && (src_col == C_LAST);
    row_last = (rep_row == Z_LAST) && (src_row == R_LAST);
    at_first = (rep_col == '0) && (src_col == '0) &&
               (rep_row == '0) && (src_row == '0);
    advance  = (state == RUN) && (!valid_reg || pix.pix_ready);
  end

  // Source frame storage. It has no reset on purpose so a frame loaded once
  // survives a reset and can be streamed again. Writes are only accepted
  // while idle so a running frame never sees its source change underneath.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && wr_en && addr_ok) begin
      pix_buf[wr_addr] <= wr_data;
    end
  end

  // Control FSM, raster counters and the output register. The output stage
  // loads a new pixel whenever it is empty or its current pixel is being
  // taken; 'more' records whether the eof pixel has been loaded yet, so the
  // handshake that takes the eof pixel is the one that closes the frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      src_col   <= '0;
      rep_col   <= '0;
      src_row   <= '0;
      rep_row   <= '0;
      more      <= 1'b0;
      valid_reg <= 1'b0;
      out_reg   <= '0;
      sof_reg   <= 1'b0;
      eol_reg   <= 1'b0;
      eof_reg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            more    <= 1'b1;
            src_col <= '0;
            rep_col <= '0;
            src_row <= '0;
            rep_row <= '0;
          end
        end

        RUN: begin
          if (advance) begin
            if (more) begin
              valid_reg <= 1'b1;
              out_reg   <= pix_buf[rd_addr];
              sof_reg   <= at_first;
              eol_reg   <= col_last;
              eof_reg   <= col_last && row_last;
              if (col_last && row_last) begin
                more <= 1'b0;
              end

              // Innermost to outermost: horizontal repeat, source column,
              // vertical repeat, source row.
              if (rep_col == Z_LAST) begin
                rep_col <= '0;
                if (src_col == C_LAST) begin
                  src_col <= '0;
                  if (rep_row == Z_LAST) begin
                    rep_row <= '0;
                    if (src_row == R_LAST) begin
                      src_row <= '0;
                    end else begin
                      src_row <= src_row + 1'b1;
                    end
                  end else begin
                    rep_row <= rep_row + 1'b1;
                  end
                end else begin
                  src_col <= src_col + 1'b1;
                end
              end else begin
                rep_col <= rep_col + 1'b1;
              end
            end else begin
              // The eof pixel is being taken and nothing is left to send.
              valid_reg <= 1'b0;
              sof_reg   <= 1'b0;
              eol_reg   <= 1'b0;
              eof_reg   <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
